// File: rtl/load_store_unit_if.sv
// CPU request/response channel plus the word-wide data-memory port of the load/store unit.
interface load_store_unit_if #(
    parameter int unsigned MEMORY_BITS = 10
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_write;
    logic [2:0]             req_funct3;
    logic [31:0]            req_addr;
    logic [31:0]            req_wdata;
    logic                   resp_valid;
    logic [31:0]            resp_rdata;
    logic                   resp_err;
    logic                   mem_read_en;
    logic                   mem_write_en;
    logic [MEMORY_BITS-1:0] mem_addr;
    logic [31:0]            mem_wdata;
    logic [31:0]            mem_rdata;

    // Master is the CPU plus the memory model; slave is the load/store unit.
    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_read_en, mem_write_en, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_read_en, mem_write_en, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Data-memory initiator: one RV32 load/store at a time, sub-word stores done as read-modify-write.
module load_store_unit #(
    parameter int unsigned MEMORY_BITS = 10
) (
    input  logic             clock,
    input  logic             rst,
    load_store_unit_if.slave bus
);
    localparam int unsigned ADDR_HI = MEMORY_BITS + 2;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_write,       w_write;
    logic [2:0]             r_funct3,      w_funct3;
    logic [1:0]             r_addr_lo,     w_addr_lo;
    logic [31:0]            r_wdata,       w_wdata;
    logic [MEMORY_BITS-1:0] r_mem_addr,    w_mem_addr;
    logic [31:0]            r_mem_wdata,   w_mem_wdata;
    logic [31:0]            r_resp_rdata,  w_resp_rdata;
    logic                   r_resp_err,    w_resp_err;
    logic                   r_req_ready;
    logic                   r_resp_valid;
    logic                   r_mem_read_en;
    logic                   r_mem_write_en;

    logic                   w_accept;
    logic                   w_funct3_ok;
    logic                   w_misaligned;
    logic                   w_out_of_range;
    logic                   w_req_err;
    logic [4:0]             w_shift;
    logic [15:0]            w_lane;
    logic [31:0]            w_lane_mask;
    logic [31:0]            w_merged;
    logic [31:0]            w_load_data;

    // Request legality, evaluated on the live request while idle.
    assign w_accept       = bus.req_valid && r_req_ready;
    assign w_funct3_ok    = bus.req_write ? (bus.req_funct3 inside {3'b000, 3'b001, 3'b010})
                                          : (bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign w_misaligned   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                            ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    assign w_out_of_range = (bus.req_addr >> ADDR_HI) != 32'd0;
    assign w_req_err      = !w_funct3_ok || w_misaligned || w_out_of_range;

    // Lane extraction for loads and lane merge for sub-word stores.
    assign w_shift     = {r_addr_lo, 3'b000};
    assign w_lane      = 16'(bus.mem_rdata >> w_shift);
    assign w_lane_mask = (r_funct3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << w_shift;
    assign w_merged    = (bus.mem_rdata & ~w_lane_mask) | ((r_wdata << w_shift) & w_lane_mask);

    always_comb begin
        w_load_data = bus.mem_rdata;
        unique case (r_funct3)
            3'b000:  w_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_load_data = {{16{w_lane[15]}}, w_lane};
            3'b100:  w_load_data = {24'd0, w_lane[7:0]};
            3'b101:  w_load_data = {16'd0, w_lane};
            default: w_load_data = bus.mem_rdata;
        endcase
    end

    // Next-state and next-register values.
    always_comb begin
        w_state_next = r_state;
        w_write      = r_write;
        w_funct3     = r_funct3;
        w_addr_lo    = r_addr_lo;
        w_wdata      = r_wdata;
        w_mem_addr   = r_mem_addr;
        w_mem_wdata  = r_mem_wdata;
        w_resp_rdata = r_resp_rdata;
        w_resp_err   = r_resp_err;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_write      = bus.req_write;
                    w_funct3     = bus.req_funct3;
                    w_addr_lo    = bus.req_addr[1:0];
                    w_wdata      = bus.req_wdata;
                    w_mem_addr   = bus.req_addr[MEMORY_BITS+1:2];
                    w_mem_wdata  = bus.req_wdata;
                    w_resp_rdata = 32'd0;
                    w_resp_err   = w_req_err;
                    if (w_req_err)
                        w_state_next = RESP;
                    else if (bus.req_write && (bus.req_funct3 == 3'b010))
                        w_state_next = WRITE;
                    else
                        w_state_next = READ;
                end
            end
            READ: begin
                if (r_write) begin
                    w_mem_wdata  = w_merged;
                    w_state_next = WRITE;
                end else begin
                    w_resp_rdata = w_load_data;
                    w_state_next = RESP;
                end
            end
            WRITE:   w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs are registered as a decode of the next state.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state        <= IDLE;
            r_write        <= 1'b0;
            r_funct3       <= 3'd0;
            r_addr_lo      <= 2'd0;
            r_wdata        <= 32'd0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= 32'd0;
            r_resp_rdata   <= 32'd0;
            r_resp_err     <= 1'b0;
            r_req_ready    <= 1'b1;
            r_resp_valid   <= 1'b0;
            r_mem_read_en  <= 1'b0;
            r_mem_write_en <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_write        <= w_write;
            r_funct3       <= w_funct3;
            r_addr_lo      <= w_addr_lo;
            r_wdata        <= w_wdata;
            r_mem_addr     <= w_mem_addr;
            r_mem_wdata    <= w_mem_wdata;
            r_resp_rdata   <= w_resp_rdata;
            r_resp_err     <= w_resp_err;
            r_req_ready    <= (w_state_next == IDLE);
            r_resp_valid   <= (w_state_next == RESP);
            r_mem_read_en  <= (w_state_next == READ);
            r_mem_write_en <= (w_state_next == WRITE);
        end
    end

    assign bus.req_ready    = r_req_ready;
    assign bus.resp_valid   = r_resp_valid;
    assign bus.resp_rdata   = r_resp_rdata;
    assign bus.resp_err     = r_resp_err;
    assign bus.mem_read_en  = r_mem_read_en;
    assign bus.mem_write_en = r_mem_write_en;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_wdata    = r_mem_wdata;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios then random traffic against a byte-level reference model.
module tb_load_store_unit;
    localparam int unsigned MB    = 10;
    localparam int unsigned WORDS = 1 << MB;

    logic clock = 1'b0;
    logic rst;
    bit   mem_init = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [31:0] dev_mem [WORDS];
    logic [31:0] ref_mem [WORDS];

    load_store_unit_if #(.MEMORY_BITS(MB)) bus ();

    load_store_unit #(.MEMORY_BITS(MB)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Word memory: samples on negedge, registered read data.
    always @(negedge clock) begin
        if (!mem_init) begin
            for (int i = 0; i < int'(WORDS); i++) dev_mem[i] <= ref_mem[i];
            mem_init <= 1'b1;
        end else begin
            if (bus.mem_write_en) dev_mem[bus.mem_addr] <= bus.mem_wdata;
            if (bus.mem_read_en)  bus.mem_rdata <= dev_mem[bus.mem_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Architectural model: RV32 byte-addressed semantics over a word array.
    task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] e_rdata, output logic e_err,
                         output int e_lat, output int e_reads, output int e_writes,
                         output logic [31:0] e_word);
        int unsigned size;
        int unsigned off;
        int unsigned idx;
        bit          legal;
        logic [31:0] word;
        logic [31:0] mask;
        logic [31:0] val;
        size  = 2 ** f3[1:0];
        legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        e_err = !legal || (addr % size != 0) || (addr >= 4 * WORDS);
        e_rdata  = 32'd0;
        e_word   = 32'd0;
        e_reads  = 0;
        e_writes = 0;
        e_lat    = 1;
        if (!e_err) begin
            idx  = addr / 4;
            off  = addr % 4;
            word = ref_mem[idx];
            if (!wr) begin
                val = word >> (8 * off);
                if (size < 4) begin
                    mask = (32'd1 << (8 * size)) - 32'd1;
                    val  = val & mask;
                    if (!f3[2] && val[8 * size - 1]) val = val | ~mask;
                end
                e_rdata = val;
                e_reads = 1;
                e_lat   = 2;
            end else begin
                for (int k = 0; k < int'(size); k++)
                    word[8 * (int'(off) + k) +: 8] = wd[8 * k +: 8];
                ref_mem[idx] = word;
                e_word   = word;
                e_writes = 1;
                e_reads  = (size < 4) ? 1 : 0;
                e_lat    = (size < 4) ? 3 : 2;
            end
        end
    endtask

    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] got);
        logic [31:0] e_rdata;
        logic [31:0] e_word;
        logic        e_err;
        int          e_lat, e_reads, e_writes;
        int          lat, nrd, nwr;
        bit          seen;
        lat = 0; nrd = 0; nwr = 0; seen = 0; got = 32'd0;
        model(wr, f3, addr, wd, e_rdata, e_err, e_lat, e_reads, e_writes, e_word);
        @(negedge clock);
        check_eq("ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clock);
        #1;
        // Junk on the request bus while busy must be ignored.
        bus.req_valid  = 1'($urandom_range(0, 1));
        bus.req_write  = 1'($urandom_range(0, 1));
        bus.req_funct3 = 3'($urandom_range(0, 7));
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(negedge clock);
            if (bus.mem_read_en || bus.mem_write_en) begin
                check_eq("enable_excl", 32'(bus.mem_read_en & bus.mem_write_en), 32'd0);
                check_eq("mem_addr", 32'(bus.mem_addr), 32'(addr[MB+1:2]));
            end
            if (bus.mem_read_en) nrd++;
            if (bus.mem_write_en) begin
                nwr++;
                check_eq("mem_wdata", bus.mem_wdata, e_word);
            end
            if (bus.resp_valid) begin
                seen = 1;
                lat  = c;
                got  = bus.resp_rdata;
                bus.req_valid = 1'b0;
                check_eq("resp_rdata", bus.resp_rdata, e_rdata);
                check_eq("resp_err", 32'(bus.resp_err), 32'(e_err));
                check_eq("ready_resp", 32'(bus.req_ready), 32'd0);
            end
        end
        check_eq("latency", 32'(lat), 32'(e_lat));
        check_eq("read_pulses", 32'(nrd), 32'(e_reads));
        check_eq("write_pulses", 32'(nwr), 32'(e_writes));
        if (!seen) begin
            bus.req_valid = 1'b0;
            rst = 1'b1;
            @(posedge clock);
            #1;
            rst = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] addr;
        int          nwe, nrv, bad, resp_a, resp_b, nready, idx;

        for (int i = 0; i < int'(WORDS); i++) ref_mem[i] = $urandom;
        ref_mem[3] = 32'h8081_82F3;
        ref_mem[5] = 32'h1122_3344;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_ready", 32'(bus.req_ready), 32'd1);
        check_eq("rst_valid", 32'(bus.resp_valid), 32'd0);
        check_eq("rst_err", 32'(bus.resp_err), 32'd0);
        check_eq("rst_rdata", bus.resp_rdata, 32'd0);
        check_eq("rst_en", 32'({bus.mem_read_en, bus.mem_write_en}), 32'd0);
        check_eq("rst_addr", 32'(bus.mem_addr), 32'd0);
        check_eq("rst_wdata", bus.mem_wdata, 32'd0);
        rst = 1'b0;

        // Load formatting on a known word.
        do_req(1'b0, 3'b000, 32'h0C, 32'd0, got); check_eq("plan_lb",  got, 32'hFFFF_FFF3);
        do_req(1'b0, 3'b101, 32'h0E, 32'd0, got); check_eq("plan_lhu", got, 32'h0000_8081);
        do_req(1'b0, 3'b001, 32'h0E, 32'd0, got); check_eq("plan_lh",  got, 32'hFFFF_8081);
        do_req(1'b0, 3'b100, 32'h0D, 32'd0, got); check_eq("plan_lbu", got, 32'h0000_0082);
        // Sub-word and word stores.
        do_req(1'b1, 3'b000, 32'h16, 32'h0000_00AB, got);
        do_req(1'b0, 3'b010, 32'h14, 32'd0, got); check_eq("plan_sb_lw", got, 32'h11AB_3344);
        do_req(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, got);
        do_req(1'b1, 3'b001, 32'h22, 32'h0000_1234, got);
        do_req(1'b0, 3'b010, 32'h20, 32'd0, got); check_eq("plan_sh_lw", got, 32'h1234_BEEF);
        // Rejected requests.
        do_req(1'b0, 3'b010, 32'h02,   32'd0, got);
        do_req(1'b1, 3'b001, 32'h01,   32'h5555_5555, got);
        do_req(1'b0, 3'b010, 32'h1000, 32'd0, got);
        do_req(1'b0, 3'b011, 32'h0C,   32'd0, got);

        // Reset while an sb sits in its read phase.
        @(negedge clock);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h16;
        bus.req_wdata  = 32'h0000_0055;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clock);
        #1;
        rst = 1'b0;
        nwe = 0; nrv = 0;
        @(negedge clock);
        check_eq("rst_mid_ready", 32'(bus.req_ready), 32'd1);
        for (int c = 0; c < 4; c++) begin
            if (bus.mem_write_en) nwe++;
            if (bus.resp_valid) nrv++;
            @(negedge clock);
        end
        check_eq("rst_mid_writes", 32'(nwe), 32'd0);
        check_eq("rst_mid_resp", 32'(nrv), 32'd0);
        check_eq("rst_mid_word", dev_mem[5], 32'h11AB_3344);

        // Back-to-back loads with req_valid held high.
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h14;
        resp_a = 0; resp_b = 0; nready = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (bus.req_ready) nready++;
            if (bus.resp_valid) begin
                check_eq("b2b_rdata", bus.resp_rdata, 32'h11AB_3344);
                if (resp_a == 0) resp_a = c;
                else if (resp_b == 0) begin
                    resp_b = c;
                    bus.req_valid = 1'b0;
                end
            end
        end
        check_eq("b2b_first", 32'(resp_a), 32'd2);
        check_eq("b2b_second", 32'(resp_b), 32'd5);
        check_eq("b2b_ready_gap", 32'(nready), 32'd6);

        // Random traffic concentrated on a few words so stores and loads interact.
        for (int t = 0; t < 300; t++) begin
            idx = $urandom_range(0, 9);
            if (idx == 0)      addr = $urandom;
            else if (idx == 1) addr = 32'(4 * WORDS) + 32'($urandom_range(0, 64));
            else               addr = 32'($urandom_range(0, 63));
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, $urandom, got);
        end

        repeat (2) @(negedge clock);
        bad = 0;
        for (int i = 0; i < int'(WORDS); i++) if (dev_mem[i] !== ref_mem[i]) bad++;
        check_eq("mem_sweep", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
